// File: rtl/itlb_pkg.sv
// rtl/itlb_pkg.sv - shared widths and entry record for the instruction TLB store
// Purpose: sizes of the translation store and the per-entry record.
// Ports: none (package).
package itlb_pkg;

  localparam int ENTRIES    = 16;
  localparam int VPN_W      = 20;
  localparam int PFN_W      = 20;
  localparam int IDX_W      = $clog2(ENTRIES);
  localparam int PAGE_OFF_W = 12;
  localparam int PADDR_W    = PFN_W + PAGE_OFF_W;

  typedef struct packed {
    logic             vld;
    logic [VPN_W-1:0] tag;
    logic [PFN_W-1:0] pfn;
  } tlb_entry_t;

endpackage

// File: rtl/itlb_entry_store_if.sv
// rtl/itlb_entry_store_if.sv - request/response bundle between the itlb and its entry store
// Purpose: groups lookup, refill and invalidate requests with the lookup response.
// Ports (signals): ena_r_i/vaddr_i lookup, ena_w_i/addr_i/paddr_w_i refill,
//   inv_all_i invalidate; paddr_r_o/valid_r_o lookup result, busy_o advisory.
// Modports: master = itlb (requester), slave = entry store (responder).
interface itlb_entry_store_if;
  import itlb_pkg::*;

  logic               ena_r_i;
  logic [VPN_W-1:0]   vaddr_i;
  logic               ena_w_i;
  logic [IDX_W-1:0]   addr_i;
  logic [PFN_W-1:0]   paddr_w_i;
  logic               inv_all_i;
  logic [PADDR_W-1:0] paddr_r_o;
  logic               valid_r_o;
  logic               busy_o;

  modport master (
    output ena_r_i, vaddr_i, ena_w_i, addr_i, paddr_w_i, inv_all_i,
    input  paddr_r_o, valid_r_o, busy_o
  );

  modport slave (
    input  ena_r_i, vaddr_i, ena_w_i, addr_i, paddr_w_i, inv_all_i,
    output paddr_r_o, valid_r_o, busy_o
  );

endinterface

// File: rtl/tlb_prio_enc.sv
// rtl/tlb_prio_enc.sv - lowest-index priority encoder for the TLB match vector
// Purpose: reduces the per-entry match vector to a hit flag and winning index.
// Ports: match_i (ENTRIES) in; hit_o out; idx_o (IDX_W) lowest set index out.
module tlb_prio_enc
  import itlb_pkg::*;
(
  input  logic [ENTRIES-1:0] match_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    hit_o = |match_i;
    idx_o = '0;
    // Scan from the top so the lowest matching index is the last write.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/itlb_entry_store.sv
// rtl/itlb_entry_store.sv - 16-entry fully associative instruction translation store
// Purpose: answers itlb lookups one cycle after request, accepts refills with
//   duplicate-tag purge, and supports a whole-store invalidate.
// Ports: clk (rising edge), rst (async active-low), bus (slave side of
//   itlb_entry_store_if carrying requests in and paddr_r_o/valid_r_o/busy_o out).
module itlb_entry_store
  import itlb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  itlb_entry_store_if.slave   bus
);

  tlb_entry_t         entries [ENTRIES];
  logic [ENTRIES-1:0] match_vec;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [PADDR_W-1:0] paddr_q;
  logic               valid_q;
  logic               busy_q;

  // The same compare serves lookup and refill purge since both key on vaddr_i.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = entries[i].vld && (entries[i].tag == bus.vaddr_i);
    end
  end

  tlb_prio_enc u_prio_enc (
    .match_i (match_vec),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (bus.inv_all_i) begin
      // Invalidate wins over a simultaneous refill; the refill is dropped.
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].vld <= 1'b0;
      end
    end else if (bus.ena_w_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.addr_i == IDX_W'(i)) begin
          entries[i].vld <= 1'b1;
          entries[i].tag <= bus.vaddr_i;
          entries[i].pfn <= bus.paddr_w_i;
        end else if (match_vec[i]) begin
          // Keep tags unique so a lookup never sees more than one hit.
          entries[i].vld <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      paddr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= bus.ena_r_i && hit;
      busy_q  <= bus.ena_w_i || bus.inv_all_i;
      // paddr holds its last value on idle cycles; a miss clears it.
      if (bus.ena_r_i) begin
        paddr_q <= hit ? {entries[hit_idx].pfn, {PAGE_OFF_W{1'b0}}} : '0;
      end
    end
  end

  assign bus.paddr_r_o = paddr_q;
  assign bus.valid_r_o = valid_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_itlb_entry_store.sv
// tb/tb_itlb_entry_store.sv - scoreboard bench for itlb_entry_store
module tb_itlb_entry_store;
  import itlb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  itlb_entry_store_if bus ();

  itlb_entry_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;

  // Each entry: {expected valid, expected paddr}
  logic [PADDR_W:0] exp_q [$];
  logic             rsp_due;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A response is due the cycle after the edge that sampled ena_r_i.
  always @(posedge clk or negedge rst) begin
    if (!rst) rsp_due <= 1'b0;
    else      rsp_due <= bus.ena_r_i;
  end

  always @(negedge clk) begin
    if (rsp_due) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [PADDR_W:0] e;
        e = exp_q.pop_front();
        chk("lookup_valid", {31'd0, bus.valid_r_o}, {31'd0, e[PADDR_W]});
        chk("lookup_paddr", bus.paddr_r_o, e[PADDR_W-1:0]);
      end
    end
  end

  // One clock of stimulus; called #1 after a rising edge and returns likewise.
  task automatic cyc(input logic r, input logic w, input logic inv,
                     input logic [VPN_W-1:0] va, input logic [IDX_W-1:0] idx,
                     input logic [PFN_W-1:0] pfn,
                     input logic exp_v, input logic [31:0] exp_p);
    bus.ena_r_i   = r;
    bus.ena_w_i   = w;
    bus.inv_all_i = inv;
    bus.vaddr_i   = va;
    bus.addr_i    = idx;
    bus.paddr_w_i = pfn;
    if (r) exp_q.push_back({exp_v, exp_p});
    @(posedge clk);
    #1;
    chk("busy", {31'd0, bus.busy_o}, {31'd0, (w | inv)});
    bus.ena_r_i   = 1'b0;
    bus.ena_w_i   = 1'b0;
    bus.inv_all_i = 1'b0;
  endtask

  task automatic look(input logic [VPN_W-1:0] va, input logic v, input logic [31:0] p);
    cyc(1'b1, 1'b0, 1'b0, va, '0, '0, v, p);
  endtask

  task automatic fill(input logic [IDX_W-1:0] idx, input logic [VPN_W-1:0] va,
                      input logic [PFN_W-1:0] pfn);
    cyc(1'b0, 1'b1, 1'b0, va, idx, pfn, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena_r_i = 0; bus.ena_w_i = 0; bus.inv_all_i = 0;
    bus.vaddr_i = '0; bus.addr_i = '0; bus.paddr_w_i = '0;

    #12;
    chk("reset_valid", {31'd0, bus.valid_r_o}, 32'd0);
    chk("reset_paddr", bus.paddr_r_o, 32'd0);
    chk("reset_busy",  {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    look(20'h00400, 1'b0, 32'h0);
    fill(4'd3, 20'h00400, 20'h1FC00);
    look(20'h00400, 1'b1, 32'h1FC00000);
    // Idle cycle: valid drops, paddr holds.
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 32'h0);
    chk("idle_valid", {31'd0, bus.valid_r_o}, 32'd0);
    chk("idle_paddr_hold", bus.paddr_r_o, 32'h1FC00000);

    // Duplicate tag refill purges idx 3, so idx 9 answers.
    fill(4'd9, 20'h00400, 20'h00001);
    look(20'h00400, 1'b1, 32'h00001000);

    // Old mapping back in idx 3 (purges 9), then same-cycle lookup + refill.
    fill(4'd3, 20'h00400, 20'h1FC00);
    cyc(1'b1, 1'b1, 1'b0, 20'h00400, 4'd5, 20'h0ABCD, 1'b1, 32'h1FC00000);
    look(20'h00400, 1'b1, 32'h0ABCD000);

    // Miss clears paddr; back-to-back lookups.
    look(20'h12345, 1'b0, 32'h0);
    fill(4'd0, 20'h00ABC, 20'h00777);
    look(20'h00ABC, 1'b1, 32'h00777000);
    look(20'h00400, 1'b1, 32'h0ABCD000);
    look(20'h00ABC, 1'b1, 32'h00777000);

    // Invalidate beats a simultaneous refill.
    cyc(1'b0, 1'b1, 1'b1, 20'h00DEF, 4'd0, 20'h12345, 1'b0, 32'h0);
    look(20'h00400, 1'b0, 32'h0);
    look(20'h00ABC, 1'b0, 32'h0);
    look(20'h00DEF, 1'b0, 32'h0);

    // Reset right after a hitting lookup.
    fill(4'd7, 20'h00400, 20'h1FC00);
    look(20'h00400, 1'b1, 32'h1FC00000);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, bus.valid_r_o}, 32'd0);
    chk("rst_async_paddr", bus.paddr_r_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    look(20'h00400, 1'b0, 32'h0);
    look(20'h00ABC, 1'b0, 32'h0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
